alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU that replaces the single-cycle combinational ALU in the pipeline's EX stage. Single-cycle ops (ADD, SUB, AND, OR, SLT) return in one cycle. MUL, and optionally DIV, run iteratively over WIDTH cycles. Operands are captured on a valid/ready handshake, so the hazard unit can stall EX while `busy_o` is high.

## Interface
- `WIDTH`, default 32: operand/result width, must be ≥ 4.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width (derived, do not override).
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_i`  in  1  synchronous active-high reset.
- `valid_i`  in  1  request valid; operands/op sampled when `valid_i && ready_o`.
- `data0_i`  in  WIDTH  operand A.
- `data1_i`  in  WIDTH  operand B.
- `ALUCtrl_i`  in  3  opcode.
- `ready_o`  out  1  unit can accept a request this cycle.
- `busy_o`  out  1  iterative op in progress.
- `valid_o`  out  1  one-cycle pulse: result outputs are fresh.
- `data_o`  out  WIDTH  result low word / quotient.
- `data_hi_o`  out  WIDTH  product high word (MUL) / remainder (DIV), else 0.
- `zero_o`  out  1  `data_o == 0`.
- `ovf_o`  out  1  signed overflow for ADD/SUB, else 0.

## Operation
- Opcodes:
  - 000 ADD, 001 SUB, 010 MUL (unsigned, 2·WIDTH product), 011 AND, 100 OR.
  - 101 SLT: signed A<B → 1, else 0.
  - 110 DIV (macro only, unsigned), 111 invalid.
- Invalid opcode, or 110 without the macro: result 0, `zero_o`=1, single-cycle latency. NOOP must have no side effect.
- FSM states:
  - IDLE → DONE on accept of a single-cycle op; result is computed and registered at the accept edge.
  - IDLE/DONE → ITER on accept of MUL/DIV; operands are latched, the counter is loaded with WIDTH.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV) step per cycle, counter decrements. When the counter reaches 1, the next edge → DONE.
  - DONE: `valid_o`=1 for exactly this cycle. Next edge → IDLE, or directly to DONE/ITER if a new request is accepted.
- `ready_o` = 1 in IDLE and DONE, 0 in ITER. `busy_o` = (state == ITER).
- Inputs are ignored while in ITER; operand changes there have no effect.
- Result registers (`data_o`, `data_hi_o`, `zero_o`, `ovf_o`) hold their last value until the next DONE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - `ovf_o` = sign(A) == sign(±B) && sign(result) != sign(A).
  - MUL: `data_o` = product[WIDTH-1:0], `data_hi_o` = product[2W-1:W].
- DIV by zero: `data_o` = all ones, `data_hi_o` = A, no trap.
- Reset, including mid-ITER: state IDLE, all outputs 0 except `ready_o`=1. An aborted op never produces `valid_o`.

## Timing
- Single-cycle op accepted at edge N: `valid_o` high in cycle N+1 (latency 1). Back-to-back issue gives throughput 1 op/cycle.
- MUL/DIV accepted at edge N: ITER for cycles N+1…N+WIDTH, `valid_o` in cycle N+WIDTH+1. `ready_o` is low for WIDTH cycles.
- A request accepted in DONE does not disturb the result currently being presented; the new result appears at the next DONE.
- All outputs are registered; there is no combinational input→output path except `ready_o`, which depends on state only.

## Configuration
- `ALU_MC_DIV_EN` defined: opcode 110 performs unsigned restoring division with the same latency as MUL.
- `ALU_MC_DIV_EN` undefined: divide datapath is not compiled; 110 is treated as invalid (result 0, latency 1).

## Structure
- Package `alu_mc_pkg`:
  - opcode localparams OP_ADD…OP_DIV, OP_INVALID.
  - FSM state enum {S_IDLE, S_ITER, S_DONE}.
- Sub-module `alu_mc_iter`: iterative MUL/DIV datapath with accumulator, shift registers and counter, started and completion-flagged by the top FSM. Single-cycle ops and output registers stay in the top.

## Test plan
- WIDTH=32: ADD 7+5 → `valid_o` 1 cycle later, `data_o`=12, `zero_o`=0, `ovf_o`=0. ADD 0x7FFFFFFF+1 → 0x80000000, `ovf_o`=1.
- SUB 5−5 → `data_o`=0, `zero_o`=1. SLT −1 vs 1 → 1. Opcode 111 → 0, `zero_o`=1.
- MUL 0xFFFFFFFF×2 → `ready_o` low 32 cycles, `valid_o` in cycle 33, `data_o`=0xFFFFFFFE, `data_hi_o`=1. Operands toggled during ITER leave the result unchanged.
- Back-to-back: ADD, AND, OR issued on 3 consecutive cycles → 3 consecutive `valid_o` pulses with the correct in-order results.
- Reset asserted at ITER cycle 10 of a MUL → next cycle IDLE, outputs 0, `ready_o`=1, no `valid_o` pulse.
- With `ALU_MC_DIV_EN`, WIDTH=8: DIV 100/7 → `data_o`=14, `data_hi_o`=2 after 9 cycles. DIV 9/0 → 0xFF, remainder 9. Without the macro, DIV 100/7 → 0 after 1 cycle.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc shared opcodes, FSM states and op classification; ALU_MC_DIV_EN enables opcode 110 (DIV).
// No logic state here; is_iter_op decides which opcodes take the WIDTH-cycle path.
package alu_mc_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_MUL     = 3'b010;
  localparam logic [2:0] OP_AND     = 3'b011;
  localparam logic [2:0] OP_OR      = 3'b100;
  localparam logic [2:0] OP_SLT     = 3'b101;
  localparam logic [2:0] OP_DIV     = 3'b110;
  localparam logic [2:0] OP_INVALID = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [2:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative shift-add multiplier and (with ALU_MC_DIV_EN) restoring divider, one step per cycle.
// start_i loads operands and a WIDTH count; lo_o/hi_o show the next-step value so the top can latch the final step.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef ALU_MC_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   add_sum;
`ifdef ALU_MC_DIV_EN
  logic             div_q;
  logic [WIDTH+1:0] trial;
`endif

  // acc holds product high word / partial remainder, mq holds multiplier / dividend-quotient
  always_comb begin
    acc_d   = acc_q;
    mq_d    = mq_q;
    add_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
`ifdef ALU_MC_DIV_EN
    trial   = {1'b0, acc_q, mq_q[WIDTH-1]} - {2'b00, opnd_q};
    if (div_q) begin
      if (trial[WIDTH+1:WIDTH] == 2'b00) begin
        acc_d = trial[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      acc_d = add_sum[WIDTH:1];
      mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      mq_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
`ifdef ALU_MC_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (start_i) begin
      acc_q  <= '0;
      cnt_q  <= CNT_LOAD;
`ifdef ALU_MC_DIV_EN
      div_q  <= div_i;
      mq_q   <= div_i ? a_i : b_i;
      opnd_q <= div_i ? b_i : a_i;
`else
      mq_q   <= b_i;
      opnd_q <= a_i;
`endif
    end else if (cnt_q != '0) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign last_o = (cnt_q == CNT_ONE);
  assign lo_o   = mq_d;
  assign hi_o   = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: ADD/SUB/AND/OR/SLT in 1 cycle, MUL (and DIV with ALU_MC_DIV_EN) in WIDTH+1 cycles.
// Valid/ready accept; ready_o drops for the WIDTH iteration cycles, valid_o pulses once per result.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] data_hi_o,
  output logic             zero_o,
  output logic             ovf_o
);

  state_e           state_q;
  logic             valid_q, busy_q, zero_q, ovf_q;
  logic [WIDTH-1:0] data_q, data_hi_q;

  logic             accept, start_iter, iter_last;
  logic [WIDTH-1:0] iter_lo, iter_hi;
  logic [WIDTH-1:0] sum, diff, sc_res;
  logic             sc_ovf;

  assign ready_o    = (state_q != S_ITER);
  assign accept     = valid_i && ready_o;
  assign start_iter = accept && is_iter_op(ALUCtrl_i);

  assign sum  = data0_i + data1_i;
  assign diff = data0_i - data1_i;

  // DIV without the divider and OP_INVALID fall to the zero default
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUCtrl_i)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (data0_i[WIDTH-1] == data1_i[WIDTH-1]) && (sum[WIDTH-1] != data0_i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (data0_i[WIDTH-1] != data1_i[WIDTH-1]) && (diff[WIDTH-1] != data0_i[WIDTH-1]);
      end
      OP_AND:  sc_res = data0_i & data1_i;
      OP_OR:   sc_res = data0_i | data1_i;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(data0_i) < $signed(data1_i))};
      default: sc_res = '0;
    endcase
  end

  alu_mc_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_iter),
`ifdef ALU_MC_DIV_EN
    .div_i   (ALUCtrl_i == OP_DIV),
`endif
    .a_i     (data0_i),
    .b_i     (data1_i),
    .last_o  (iter_last),
    .lo_o    (iter_lo),
    .hi_o    (iter_hi)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      data_hi_q <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept && start_iter) begin
            state_q <= S_ITER;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (accept) begin
            state_q   <= S_DONE;
            valid_q   <= 1'b1;
            data_q    <= sc_res;
            data_hi_q <= '0;
            zero_q    <= (sc_res == '0);
            ovf_q     <= sc_ovf;
          end else begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        S_ITER: begin
          if (iter_last) begin
            state_q   <= S_DONE;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            data_q    <= iter_lo;
            data_hi_q <= iter_hi;
            zero_q    <= (iter_lo == '0);
            ovf_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign data_hi_o = data_hi_q;
  assign zero_o    = zero_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed cases, back-to-back issue, reset mid-ITER, random ops.
// Expected values come from an arithmetic reference model; DIV expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [W-1:0] d0, d1;
  logic [2:0]   op;
  logic         ready_o, busy_o, valid_o, zero_o, ovf_o;
  logic [W-1:0] data_o, data_hi_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid_i),
    .data0_i   (d0),
    .data1_i   (d1),
    .ALUCtrl_i (op),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .data_hi_o (data_hi_o),
    .zero_o    (zero_o),
    .ovf_o     (ovf_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode meanings.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic ovf, output int lat);
    longint sa, sb, r;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = '0; hi = '0; ovf = 1'b0; lat = 1;
    case (o)
      3'd0: begin r = sa + sb; lo = W'(r); ovf = (r != longint'($signed(lo))); end
      3'd1: begin r = sa - sb; lo = W'(r); ovf = (r != longint'($signed(lo))); end
      3'd2: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; lo = p[W-1:0]; hi = p[2*W-1:W]; lat = W + 1; end
      3'd3: lo = a & b;
      3'd4: lo = a | b;
      3'd5: lo = (sa < sb) ? 1 : 0;
`ifdef ALU_MC_DIV_EN
      3'd6: begin
        lat = W + 1;
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
`endif
      default: begin lo = '0; hi = '0; end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit toggle);
    logic [W-1:0] elo, ehi;
    logic eovf;
    int elat, cyc, rlow;
    model(o, a, b, elo, ehi, eovf, elat);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(ready_o), 64'(1));
    valid_i = 1'b1; op = o; d0 = a; d1 = b;
    @(negedge clk);
    valid_i = 1'b0;
    cyc = 1; rlow = 0;
    while (!valid_o && cyc <= 2*W + 4) begin
      if (!ready_o) begin
        rlow++;
        if (toggle) begin
          valid_i = 1'($urandom_range(0, 1));
          d0 = $urandom; d1 = $urandom; op = 3'($urandom_range(0, 7));
        end
      end
      @(negedge clk);
      cyc++;
    end
    valid_i = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(elat));
    chk({tag, "_ready_low"}, 64'(rlow), 64'(elat - 1));
    chk({tag, "_data"}, 64'(data_o), 64'(elo));
    chk({tag, "_data_hi"}, 64'(data_hi_o), 64'(ehi));
    chk({tag, "_zero"}, 64'(zero_o), 64'(elo == 0));
    chk({tag, "_ovf"}, 64'(ovf_o), 64'(eovf));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(valid_o), 64'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] blo [3];
    logic [W-1:0] bhi;
    logic [2:0]   bop [3];
    logic [W-1:0] ba [3], bb [3];
    logic         bovf;
    int           blat;
    bit           seen;

    rst = 1'b1; valid_i = 1'b0; d0 = '0; d1 = '0; op = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'(1));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    chk("rst_data_hi", 64'(data_hi_o), 64'(0));
    chk("rst_zero", 64'(zero_o), 64'(0));
    chk("rst_ovf", 64'(ovf_o), 64'(0));
    rst = 1'b0;

    run_op("add_7_5", OP_ADD, 32'd7, 32'd5, 1'b0);
    chk("add_7_5_hold", 64'(data_o), 64'd12);
    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
    chk("add_ovf_hold", 64'({ovf_o, data_o}), 64'({1'b1, 32'h8000_0000}));
    run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 1'b0);
    run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("invalid", OP_INVALID, 32'd3, 32'd4, 1'b0);
    run_op("mul_max2", OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1);
    chk("mul_max2_hold", 64'({data_hi_o, data_o}), {32'd1, 32'hFFFF_FFFE});
    run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 1'b0);
    run_op("div_9_0", OP_DIV, 32'd9, 32'd0, 1'b1);

    // ADD, AND, OR on consecutive cycles
    bop[0] = OP_ADD; bop[1] = OP_AND; bop[2] = OP_OR;
    for (int i = 0; i < 3; i++) begin
      ba[i] = $urandom | 32'h1; bb[i] = $urandom | 32'h2;
      model(bop[i], ba[i], bb[i], blo[i], bhi, bovf, blat);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; op = bop[i]; d0 = ba[i]; d1 = bb[i];
      @(negedge clk);
      chk("b2b_valid", 64'(valid_o), 64'(1));
      chk("b2b_data", 64'(data_o), 64'(blo[i]));
    end
    valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_end", 64'(valid_o), 64'(0));

    // reset during iteration 10 of a MUL
    valid_i = 1'b1; op = OP_MUL; d0 = $urandom | 32'h1; d1 = $urandom | 32'h1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", 64'(busy_o), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 64'(ready_o), 64'(1));
    chk("abort_busy_clr", 64'(busy_o), 64'(0));
    chk("abort_valid", 64'(valid_o), 64'(0));
    chk("abort_outs", 64'({zero_o, ovf_o, data_o}), 64'(0));
    chk("abort_hi", 64'(data_hi_o), 64'(0));
    seen = 1'b0;
    repeat (2*W) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'(0));

    for (int n = 0; n < 40; n++) begin
      run_op("rand", 3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
